// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: IR latch, FETCH/DECODE/EXEC/MEM/WB sequencing, retire counter, sticky errors.
// Define MCU_MEM_TIMEOUT_EN to enable the ihit/dhit wait watchdog (err[1]); otherwise memory waits are unbounded.
package cpu_types_pkg;
  typedef enum logic [5:0] {
    RTYPE = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05,
    ADDI = 6'h08, ADDIU = 6'h09, SLTI = 6'h0a, SLTIU = 6'h0b,
    ANDI = 6'h0c, ORI = 6'h0d, XORI = 6'h0e, LUI = 6'h0f,
    LW = 6'h23, SW = 6'h2b, HALT = 6'h3f
  } opcode_t;

  typedef enum logic [5:0] {
    SLLV = 6'h04, SRLV = 6'h06, JR = 6'h08,
    ADD = 6'h20, ADDU = 6'h21, SUB = 6'h22, SUBU = 6'h23,
    AND = 6'h24, OR = 6'h25, XOR = 6'h26, NOR = 6'h27,
    SLT = 6'h2a, SLTU = 6'h2b
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL = 4'b0000, ALU_SRL = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0011,
    ALU_AND = 4'b0100, ALU_OR = 4'b0101, ALU_XOR = 4'b0110, ALU_NOR = 4'b0111,
    ALU_SLT = 4'b1010, ALU_SLTU = 4'b1011
  } aluop_t;
endpackage

module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      imemload,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             zero,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             PCWEN,
  output logic [1:0]       pcsel,
  output logic             RegWEN,
  output logic [1:0]       Regdst,
  output logic [1:0]       wsel,
  output logic [1:0]       ALUsrc,
  output logic [3:0]       aluop,
  output logic [31:0]      instr,
  output logic             halt,
  output logic [1:0]       err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
    WB = 3'd4, HALTED = 3'd5, ERROR = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    K_RALU, K_IALU, K_LUI, K_LW, K_SW, K_J, K_JAL, K_JR, K_BEQ, K_BNE, K_HALT, K_ILLEGAL
  } kind_t;

  state_t           st;
  logic [31:0]      ir;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       err_q;
  kind_t            kind;
  aluop_t           op_alu;
  logic [1:0]       op_src;
  logic             wait_expired;

`ifdef MCU_MEM_TIMEOUT_EN
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  logic [WW-1:0] wcnt;
  logic          waiting;
  assign waiting      = (st == FETCH && !ihit) || (st == MEM && !dhit);
  // Fires on the WAIT_MAXth missing cycle; a hit in that same cycle still wins.
  assign wait_expired = (wcnt == WW'(WAIT_MAX - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    kind   = K_ILLEGAL;
    op_alu = ALU_SLL;
    op_src = 2'd0;
    case (opcode_t'(ir[31:26]))
      RTYPE: begin
        kind = K_RALU;
        case (funct_t'(ir[5:0]))
          SLLV:      op_alu = ALU_SLL;
          SRLV:      op_alu = ALU_SRL;
          JR:        kind   = K_JR;
          ADD, ADDU: op_alu = ALU_ADD;
          SUB, SUBU: op_alu = ALU_SUB;
          AND:       op_alu = ALU_AND;
          OR:        op_alu = ALU_OR;
          XOR:       op_alu = ALU_XOR;
          NOR:       op_alu = ALU_NOR;
          SLT:       op_alu = ALU_SLT;
          SLTU:      op_alu = ALU_SLTU;
          default:   kind   = K_ILLEGAL;
        endcase
      end
      J:           kind = K_J;
      JAL:         kind = K_JAL;
      BEQ:         begin kind = K_BEQ;  op_alu = ALU_SUB; end
      BNE:         begin kind = K_BNE;  op_alu = ALU_SUB; end
      ADDI, ADDIU: begin kind = K_IALU; op_alu = ALU_ADD;  op_src = 2'd1; end
      SLTI:        begin kind = K_IALU; op_alu = ALU_SLT;  op_src = 2'd1; end
      SLTIU:       begin kind = K_IALU; op_alu = ALU_SLTU; op_src = 2'd1; end
      ANDI:        begin kind = K_IALU; op_alu = ALU_AND;  op_src = 2'd2; end
      ORI:         begin kind = K_IALU; op_alu = ALU_OR;   op_src = 2'd2; end
      XORI:        begin kind = K_IALU; op_alu = ALU_XOR;  op_src = 2'd2; end
      LUI:         kind = K_LUI;
      LW:          begin kind = K_LW;   op_alu = ALU_ADD;  op_src = 2'd1; end
      SW:          begin kind = K_SW;   op_alu = ALU_ADD;  op_src = 2'd1; end
      HALT:        kind = K_HALT;
      default:     kind = K_ILLEGAL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st    <= FETCH;
      ir    <= '0;
      cnt   <= '0;
      err_q <= '0;
`ifdef MCU_MEM_TIMEOUT_EN
      wcnt  <= '0;
`endif
    end else begin
`ifdef MCU_MEM_TIMEOUT_EN
      wcnt <= (waiting && !wait_expired) ? wcnt + WW'(1) : '0;
`endif
      case (st)
        FETCH: begin
          if (ihit) begin
            ir <= imemload;
            st <= DECODE;
          end else if (wait_expired) begin
            err_q[1] <= 1'b1;
            st       <= ERROR;
          end
        end
        DECODE: begin
          if (kind == K_HALT) begin
            st <= HALTED;
          end else if (kind == K_ILLEGAL) begin
            err_q[0] <= 1'b1;
            st       <= ERROR;
          end else begin
            st <= EXEC;
          end
        end
        EXEC: begin
          case (kind)
            K_J, K_JR, K_BEQ, K_BNE: begin
              cnt <= cnt + CNT_W'(1);
              st  <= FETCH;
            end
            K_LW, K_SW: st <= MEM;
            default:    st <= WB;
          endcase
        end
        MEM: begin
          if (dhit) begin
            if (kind == K_LW) begin
              st <= WB;
            end else begin
              cnt <= cnt + CNT_W'(1);
              st  <= FETCH;
            end
          end else if (wait_expired) begin
            err_q[1] <= 1'b1;
            st       <= ERROR;
          end
        end
        WB: begin
          cnt <= cnt + CNT_W'(1);
          st  <= FETCH;
        end
        HALTED:  st <= HALTED;
        ERROR:   st <= ERROR;
        default: st <= FETCH;
      endcase
    end
  end

  // Outputs decode from registered state/IR; RST forces everything low combinationally.
  always_comb begin
    iREN      = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    PCWEN     = 1'b0;
    pcsel     = 2'd0;
    RegWEN    = 1'b0;
    Regdst    = 2'd0;
    wsel      = 2'd0;
    ALUsrc    = 2'd0;
    aluop     = 4'd0;
    instr     = '0;
    halt      = 1'b0;
    err       = '0;
    state     = 3'd0;
    instr_cnt = '0;
    if (!RST) begin
      instr     = ir;
      err       = err_q;
      state     = st;
      instr_cnt = cnt;
      case (st)
        FETCH:  iREN = 1'b1;
        DECODE: PCWEN = 1'b1;
        EXEC: begin
          aluop  = op_alu;
          ALUsrc = op_src;
          case (kind)
            K_J, K_JAL: begin PCWEN = 1'b1;  pcsel = 2'd1; end
            K_JR:       begin PCWEN = 1'b1;  pcsel = 2'd2; end
            K_BEQ:      begin PCWEN = zero;  pcsel = 2'd3; end
            K_BNE:      begin PCWEN = !zero; pcsel = 2'd3; end
            default:    ;
          endcase
        end
        MEM: begin
          aluop  = op_alu;
          ALUsrc = op_src;
          dREN   = (kind == K_LW);
          dWEN   = (kind == K_SW);
        end
        WB: begin
          RegWEN = 1'b1;
          case (kind)
            K_IALU:  Regdst = 2'd1;
            K_LW:    begin Regdst = 2'd1; wsel = 2'd1; end
            K_LUI:   begin Regdst = 2'd1; wsel = 2'd3; end
            K_JAL:   begin Regdst = 2'd2; wsel = 2'd2; end
            default: ;
          endcase
        end
        HALTED, ERROR: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instruction-level scoreboard model plus literal spot checks.
module tb_multicycle_control_unit;
  localparam int unsigned CW = 4;
  localparam int unsigned WM = 4;
`ifdef MCU_MEM_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
  logic [31:0] imemload = '0;
  logic iREN, dREN, dWEN, PCWEN, RegWEN, halt;
  logic [1:0] pcsel, Regdst, wsel, ALUsrc, err;
  logic [3:0] aluop;
  logic [31:0] instr;
  logic [2:0] state;
  logic [CW-1:0] instr_cnt;

  multicycle_control_unit #(.CNT_W(CW), .WAIT_MAX(WM)) dut (
    .CLK(CLK), .RST(RST), .imemload(imemload), .ihit(ihit), .dhit(dhit), .zero(zero),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .PCWEN(PCWEN), .pcsel(pcsel), .RegWEN(RegWEN),
    .Regdst(Regdst), .wsel(wsel), .ALUsrc(ALUsrc), .aluop(aluop), .instr(instr),
    .halt(halt), .err(err), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] state;
    logic iren, dren, dwen, pcwen;
    logic [1:0] pcsel;
    logic regwen;
    logic [1:0] regdst, wsel, alusrc;
    logic [3:0] aluop;
    logic halt;
    logic [1:0] err;
    logic [31:0] instr;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t dut_obs;
  assign dut_obs = {state, iREN, dREN, dWEN, PCWEN, pcsel, RegWEN, Regdst, wsel, ALUsrc,
                    aluop, halt, err, instr, instr_cnt};

  localparam int C_R = 0, C_I = 1, C_LUI = 2, C_LW = 3, C_SW = 4, C_J = 5, C_JAL = 6,
                 C_JR = 7, C_BEQ = 8, C_BNE = 9, C_HALT = 10, C_BAD = 11;

  typedef struct { int cls; logic [3:0] alu; logic [1:0] src; } info_t;
  typedef struct { logic rst, ih, dh, z; logic [31:0] im; obs_t e; } rec_t;

  rec_t q[$];
  int unsigned m_cnt;
  logic [31:0] m_ir;
  logic [1:0]  m_err;
  int          m_ph;
  int unsigned npass = 0, ncheck = 0;
  int n_dren, n_regwen, n_pcwen, first_halt, ncyc;

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'h00, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Instruction class and EXEC-time ALU controls straight from the ISA table.
  function automatic info_t info(input logic [31:0] w);
    info_t r;
    r.cls = C_BAD; r.alu = 4'd0; r.src = 2'd0;
    case (w[31:26])
      6'h00: begin
        r.cls = C_R;
        case (w[5:0])
          6'h04: r.alu = 4'd0;
          6'h06: r.alu = 4'd1;
          6'h08: r.cls = C_JR;
          6'h20, 6'h21: r.alu = 4'd2;
          6'h22, 6'h23: r.alu = 4'd3;
          6'h24: r.alu = 4'd4;
          6'h25: r.alu = 4'd5;
          6'h26: r.alu = 4'd6;
          6'h27: r.alu = 4'd7;
          6'h2a: r.alu = 4'ha;
          6'h2b: r.alu = 4'hb;
          default: r.cls = C_BAD;
        endcase
      end
      6'h02: r.cls = C_J;
      6'h03: r.cls = C_JAL;
      6'h04: begin r.cls = C_BEQ; r.alu = 4'd3; end
      6'h05: begin r.cls = C_BNE; r.alu = 4'd3; end
      6'h08, 6'h09: begin r.cls = C_I; r.alu = 4'd2; r.src = 2'd1; end
      6'h0a: begin r.cls = C_I; r.alu = 4'ha; r.src = 2'd1; end
      6'h0b: begin r.cls = C_I; r.alu = 4'hb; r.src = 2'd1; end
      6'h0c: begin r.cls = C_I; r.alu = 4'd4; r.src = 2'd2; end
      6'h0d: begin r.cls = C_I; r.alu = 4'd5; r.src = 2'd2; end
      6'h0e: begin r.cls = C_I; r.alu = 4'd6; r.src = 2'd2; end
      6'h0f: r.cls = C_LUI;
      6'h23: begin r.cls = C_LW; r.alu = 4'd2; r.src = 2'd1; end
      6'h2b: begin r.cls = C_SW; r.alu = 4'd2; r.src = 2'd1; end
      6'h3f: r.cls = C_HALT;
      default: r.cls = C_BAD;
    endcase
    return r;
  endfunction

  function automatic obs_t exp_obs(input int ph, input logic [31:0] w, input logic z);
    obs_t o;
    info_t i;
    o = '0;
    i = info(w);
    o.state = 3'(ph);
    o.instr = m_ir;
    o.cnt   = CW'(m_cnt);
    o.err   = m_err;
    case (ph)
      0: o.iren = 1'b1;
      1: o.pcwen = 1'b1;
      2: begin
        o.aluop = i.alu; o.alusrc = i.src;
        if (i.cls == C_J || i.cls == C_JAL) begin o.pcwen = 1'b1; o.pcsel = 2'd1; end
        if (i.cls == C_JR)  begin o.pcwen = 1'b1; o.pcsel = 2'd2; end
        if (i.cls == C_BEQ) begin o.pcwen = z;    o.pcsel = 2'd3; end
        if (i.cls == C_BNE) begin o.pcwen = !z;   o.pcsel = 2'd3; end
      end
      3: begin
        o.aluop = i.alu; o.alusrc = i.src;
        o.dren = (i.cls == C_LW);
        o.dwen = (i.cls == C_SW);
      end
      4: begin
        o.regwen = 1'b1;
        if (i.cls == C_I)   o.regdst = 2'd1;
        if (i.cls == C_LW)  begin o.regdst = 2'd1; o.wsel = 2'd1; end
        if (i.cls == C_LUI) begin o.regdst = 2'd1; o.wsel = 2'd3; end
        if (i.cls == C_JAL) begin o.regdst = 2'd2; o.wsel = 2'd2; end
      end
      default: o.halt = 1'b1;
    endcase
    return o;
  endfunction

  task automatic push(input logic rst, ih, dh, z, input logic [31:0] im, input int ph,
                      input logic [31:0] w);
    rec_t r;
    r.rst = rst; r.ih = ih; r.dh = dh; r.z = z; r.im = im;
    r.e = rst ? obs_t'('0) : exp_obs(ph, w, z);
    q.push_back(r);
  endtask

  task automatic retire();
    m_cnt = (m_cnt + 1) % (32'd1 << CW);
  endtask

  task automatic push_rst(input int n);
    repeat (n) push(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 0, 32'h0);
    m_ir = '0; m_cnt = 0; m_err = '0; m_ph = 0;
  endtask

  task automatic push_wait(input int n);
    repeat (n) push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 32'h0);
  endtask

  task automatic push_term(input int n);
    for (int k = 0; k < n; k++) push(1'b0, k[0], k[0], 1'b0, 32'h0, m_ph, 32'h0);
  endtask

  // Expected cycle sequence for one instruction; hits outside their phase are driven high on purpose.
  task automatic push_instr(input logic [31:0] w, input int idly, input int ddly, input logic z);
    info_t i;
    i = info(w);
    if (TO && idly >= int'(WM)) begin
      repeat (WM) push(1'b0, 1'b0, 1'b1, z, 32'hDEADBEEF, 0, w);
      m_err[1] = 1'b1; m_ph = 6;
      return;
    end
    repeat (idly) push(1'b0, 1'b0, 1'b1, z, 32'hDEADBEEF, 0, w);
    push(1'b0, 1'b1, 1'b1, z, w, 0, w);
    m_ir = w;
    push(1'b0, 1'b1, 1'b1, z, ~w, 1, w);
    if (i.cls == C_HALT) begin m_ph = 5; return; end
    if (i.cls == C_BAD) begin m_err[0] = 1'b1; m_ph = 6; return; end
    push(1'b0, 1'b1, 1'b1, z, ~w, 2, w);
    if (i.cls == C_J || i.cls == C_JR || i.cls == C_BEQ || i.cls == C_BNE) begin
      retire();
      return;
    end
    if (i.cls == C_LW || i.cls == C_SW) begin
      if (TO && ddly >= int'(WM)) begin
        repeat (WM) push(1'b0, 1'b1, 1'b0, z, ~w, 3, w);
        m_err[1] = 1'b1; m_ph = 6;
        return;
      end
      repeat (ddly) push(1'b0, 1'b1, 1'b0, z, ~w, 3, w);
      push(1'b0, 1'b0, 1'b1, z, ~w, 3, w);
      if (i.cls == C_SW) begin retire(); return; end
    end
    push(1'b0, 1'b1, 1'b1, z, ~w, 4, w);
    retire();
  endtask

  task automatic chk(input string nm, input obs_t a, input obs_t b);
    ncheck++;
    if (a === b) npass++;
    else $display("FAIL %s: dut=%h model=%h", nm, a, b);
  endtask

  task automatic chkv(input string nm, input logic [31:0] a, input logic [31:0] b);
    ncheck++;
    if (a === b) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, b);
  endtask

  task automatic run();
    rec_t r;
    n_dren = 0; n_regwen = 0; n_pcwen = 0; first_halt = 0; ncyc = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge CLK);
      #1;
      RST = r.rst; ihit = r.ih; dhit = r.dh; zero = r.z; imemload = r.im;
      @(negedge CLK);
      ncyc++;
      chk($sformatf("cycle@%0t", $time), dut_obs, r.e);
      if (dREN) n_dren++;
      if (RegWEN) n_regwen++;
      if (PCWEN) n_pcwen++;
      if (halt && first_halt == 0) first_halt = ncyc;
    end
  endtask

  task automatic settle();
    push_wait(1);
    run();
  endtask

  localparam logic [31:0] W_ADDU = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};

  initial begin
    m_cnt = 0; m_ir = '0; m_err = '0; m_ph = 0;
    push_rst(2);
    run();
    chkv("rst_iren", 32'(iREN), 32'd0);

    push_instr(W_ADDU, 0, 0, 1'b0);
    run();
    chkv("addu_cycles", 32'(ncyc), 32'd4);
    chkv("addu_regwen", 32'(n_regwen), 32'd1);
    settle();
    chkv("addu_cnt", 32'(instr_cnt), 32'd1);

    push_instr(itype(6'h23, 5'd1, 5'd5, 16'h0008), 0, 3, 1'b0);
    chkv("lw_len", 32'(q.size()), 32'd8);
    run();
    chkv("lw_dren", 32'(n_dren), 32'd4);

    push_instr(itype(6'h05, 5'd1, 5'd2, 16'h0010), 0, 0, 1'b1);
    run();
    chkv("bne_z1_pcwen", 32'(n_pcwen), 32'd1);
    push_instr(itype(6'h05, 5'd1, 5'd2, 16'h0010), 0, 0, 1'b0);
    run();
    chkv("bne_z0_pcwen", 32'(n_pcwen), 32'd2);

    push_instr(itype(6'h2b, 5'd2, 5'd6, 16'hfffc), 1, 1, 1'b0);
    push_instr(itype(6'h04, 5'd3, 5'd3, 16'h0004), 0, 0, 1'b1);
    push_instr({6'h02, 26'h0000010}, 0, 0, 1'b0);
    push_instr({6'h03, 26'h0000020}, 0, 0, 1'b0);
    push_instr(rtype(6'h08, 5'd31, 5'd0, 5'd0), 0, 0, 1'b0);
    push_instr(itype(6'h08, 5'd1, 5'd7, 16'h8000), 0, 0, 1'b0);
    push_instr(itype(6'h0d, 5'd1, 5'd8, 16'h00ff), 2, 0, 1'b0);
    push_instr(itype(6'h0b, 5'd1, 5'd9, 16'h0001), 0, 0, 1'b0);
    push_instr(itype(6'h0f, 5'd0, 5'd10, 16'h1234), 0, 0, 1'b0);
    push_instr(rtype(6'h22, 5'd4, 5'd5, 5'd11), 0, 0, 1'b0);
    push_instr(rtype(6'h04, 5'd4, 5'd5, 5'd12), 0, 0, 1'b0);
    run();
    settle();
    chkv("cnt_all_ones", 32'(instr_cnt), 32'hf);
    push_instr(rtype(6'h27, 5'd4, 5'd5, 5'd13), 0, 0, 1'b0);
    run();
    settle();
    chkv("cnt_wrap", 32'(instr_cnt), 32'd0);
    push_instr(itype(6'h0e, 5'd1, 5'd14, 16'h0f0f), 3, 0, 1'b0);
    run();

    push_instr({6'h3f, 26'h0}, 0, 0, 1'b0);
    push_term(4);
    run();
    chkv("halt_first_cycle", 32'(first_halt), 32'd3);
    chkv("halt_cnt", 32'(instr_cnt), 32'd1);

    push_rst(1);
    push_wait(1);
    run();
    chkv("rst_cnt", 32'(instr_cnt), 32'd0);
    chkv("rst_state", 32'(state), 32'd0);

    push_instr({6'h3e, 26'h0}, 0, 0, 1'b0);
    push_term(2);
    run();
    chkv("ill_op_err", 32'(err), 32'd1);
    chkv("ill_op_halt", 32'(halt), 32'd1);

    push_rst(1);
    push_instr(rtype(6'h01, 5'd1, 5'd2, 5'd3), 0, 0, 1'b0);
    push_term(1);
    run();
    chkv("ill_funct_err", 32'(err), 32'd1);

    push_rst(1);
`ifdef MCU_MEM_TIMEOUT_EN
    push_instr(W_ADDU, 6, 0, 1'b0);
    push_term(2);
    run();
    chkv("to_fetch_err", 32'(err), 32'd2);
    chkv("to_fetch_iren", 32'(iREN), 32'd0);
    push_rst(1);
    push_instr(itype(6'h2b, 5'd2, 5'd6, 16'h0000), 0, 6, 1'b0);
    push_term(2);
    run();
    chkv("to_mem_err", 32'(err), 32'd2);
    chkv("to_mem_dwen", 32'(dWEN), 32'd0);
`else
    push_instr(W_ADDU, 6, 0, 1'b0);
    run();
    settle();
    chkv("long_wait_cnt", 32'(instr_cnt), 32'd1);
    chkv("long_wait_err", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Registered-FSM controller for the multicycle MIPS datapath. It latches the fetched instruction into an internal IR and sequences FETCH/DECODE/EXEC/MEM/WB. It drives every datapath enable and mux select, and handshakes with the memory arbiter via `ihit`/`dhit`. It adds a retired-instruction counter, sticky error reporting and an optional memory watchdog.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.
- `WAIT_MAX`, 255, maximum wait cycles on `ihit`/`dhit` before a timeout; counter width is `$clog2(WAIT_MAX+1)`.
- `CLK` in 1: the only clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `imemload` in 32: instruction word; valid when `ihit`=1.
- `ihit` in 1: instruction memory done.
- `dhit` in 1: data memory done.
- `zero` in 1: ALU zero flag.
- `iREN` out 1: instruction read request.
- `dREN`, `dWEN` out 1: data read/write request.
- `PCWEN` out 1: PC write enable.
- `pcsel` out 2: 0 PC+4, 1 jump target, 2 rs, 3 branch target.
- `RegWEN` out 1: register file write enable.
- `Regdst` out 2: 0 rd, 1 rt, 2 r31.
- `wsel` out 2: writeback source; 0 ALU, 1 memory, 2 link (PC+4), 3 {imm,16'h0}.
- `ALUsrc` out 2: 0 rt, 1 sign-extended imm, 2 zero-extended imm.
- `aluop` out 4: `aluop_t` from `cpu_types_pkg`.
- `instr` out 32: IR contents.
- `halt` out 1: sticky halt.
- `err` out 2: sticky; bit0 illegal opcode/funct, bit1 memory timeout.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5, ERROR=6.
- `instr_cnt` out CNT_W: retired-instruction count.

## Operation
- **FETCH**: `iREN`=1; hold until `ihit`. On `ihit`, IR←`imemload`, go to DECODE.
- **DECODE**: `PCWEN`=1, `pcsel`=0 (one cycle).
  - Opcode HALT → HALTED.
  - Unsupported opcode, or RTYPE with unsupported funct → ERROR, `err[0]`←1.
  - Otherwise → EXEC.
- Supported RTYPE funct: SLLV, SRLV, JR, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU.
- Supported opcodes: RTYPE, J, JAL, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, HALT.
- **EXEC**: `aluop`/`ALUsrc` per instruction (SLTI→SLT, SLTIU→SLTU; ANDI/ORI/XORI use `ALUsrc`=2). Next state:
  - J: `PCWEN`=1, `pcsel`=1, retire, → FETCH.
  - JR: `PCWEN`=1, `pcsel`=2, retire, → FETCH.
  - BEQ/BNE: `aluop`=SUB, `pcsel`=3, `PCWEN`=`zero` (BEQ) or `!zero` (BNE), retire, → FETCH.
  - JAL: `PCWEN`=1, `pcsel`=1, → WB.
  - LW/SW: `aluop`=ADD, `ALUsrc`=1, → MEM.
  - All others: → WB.
- **MEM**: assert `dREN` (LW) or `dWEN` (SW), holding `aluop`/`ALUsrc`, until `dhit`. On `dhit`: LW → WB; SW → retire, → FETCH.
- **WB**: `RegWEN`=1 for one cycle, retire, → FETCH. Write selects:
  - RTYPE: `Regdst`=0, `wsel`=0.
  - I-type ALU: `Regdst`=1, `wsel`=0.
  - LW: `Regdst`=1, `wsel`=1.
  - LUI: `Regdst`=1, `wsel`=3.
  - JAL: `Regdst`=2, `wsel`=2.
- **HALTED**: `halt`=1. **ERROR**: `halt`=1 and `err` held. Both are terminal; only `RST` exits.
- Retire: `instr_cnt`+1, modulo 2^CNT_W; all-ones wraps to 0. HALT and illegal instructions are not counted.
- Unlisted outputs are 0 in every state.

## Timing
- Control outputs decode from the registered `state` and IR only. The exceptions are BEQ/BNE `PCWEN`, combinational from `zero`, and the in-state `ihit`/`dhit` exit conditions.
- While `RST`=1: every output is 0, including `iREN`. On the first edge with `RST`=1: state=FETCH, IR=0, `instr_cnt`=0, `err`=0, and the wait counter is cleared.
- `RST` asserted mid-instruction aborts it; no partial retire.
- Cycles per instruction with same-cycle hits: R/I-type/LUI/JAL 4, LW 5, SW 4, J/JR/BEQ/BNE 3, HALT reaches HALTED in 2.
- Each memory wait adds one cycle per cycle the hit is low.
- `ihit` outside FETCH and `dhit` outside MEM are ignored.

## Configuration
- `MCU_MEM_TIMEOUT_EN` defined:
  - The wait counter increments each FETCH/MEM cycle without a hit and clears on state exit.
  - When it reaches `WAIT_MAX` without a hit: → ERROR with `err[1]`←1, and `iREN`/`dREN`/`dWEN` drop the next cycle.
  - A hit on the `WAIT_MAX`th cycle wins over the timeout.
- Undefined: no counter; FETCH/MEM wait indefinitely; `err[1]` is tied 0.

## Test plan
- Reset, then ADDU $3,$1,$2 with immediate `ihit` → states 0,1,2,4; `RegWEN`=1 only in WB, `Regdst`=0, `aluop`=ADD; `instr_cnt`=1 after WB.
- LW with `dhit` delayed 3 cycles → `dREN` high for exactly 4 MEM cycles; WB has `wsel`=1, `Regdst`=1; total 8 cycles.
- BNE with `zero`=1, then BNE with `zero`=0 → `PCWEN` in EXEC is 0, then 1 with `pcsel`=3; both retire.
- Opcode 0x3F (HALT) → `halt`=1 from the third cycle on; `instr_cnt` unchanged; further `ihit` pulses ignored; `RST` returns to FETCH with `instr_cnt`=0.
- Illegal opcode 0x3E → ERROR, `err`=2'b01, `halt`=1.
- With `MCU_MEM_TIMEOUT_EN` and `WAIT_MAX`=4, hold `ihit`=0 → ERROR with `err`=2'b10 after 4 FETCH cycles. `ihit` on the 4th cycle instead → DECODE.
